pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards and taken branches, and runs a multi-cycle data-memory wait handshake. It drives per-register enable/flush/bubble controls plus the PC enable. It also keeps a stall-cycle counter and raises a sticky fault on memory timeout.

Parameters:
TIMEOUT, 16, max cycles in MWAIT before fault (>=2)
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_usesRt  in  1  ID instruction reads rt as a source
ex_memRead  in  1  instruction in EX is a load
ex_rt  in  5  destination rt of EX load
ex_branchTaken  in  1  branch/jump resolved taken in EX
mem_memAccess  in  1  instruction in MEM is a load or store
mem_ready  in  1  data memory completes access this cycle
mem_req  out  1  data-memory access pending/held
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX load bubble (all control 0)
exmem_en  out  1  EX/MEM load enable
memwb_bubble  out  1  MEM/WB loads bubble (regWrite=0, memToReg=0)
stall_cycles  out  CNT_W  count of cycles with pc_en=0
fault  out  1  sticky memory-timeout error

Behaviour:
- State reg: RUN, MWAIT, FAULT; wait_cnt (clog2(TIMEOUT+1) bits); stall_cycles; fault. All asynchronously cleared on reset=0: state RUN, wait_cnt 0, stall_cycles 0, fault 0.
- Outputs are combinational from state and inputs. While reset=0: all *_en=0, all flush/bubble=0, mem_req=0.
- Default (no event): all enables 1, flushes/bubble 0, mem_req=mem_memAccess.
- Priority in RUN: memory stall > branch > load-use.
- Memory stall (RUN, mem_memAccess=1, mem_ready=0): pc_en, ifid_en, idex_en, exmem_en = 0; memwb_bubble=1; mem_req=1; next MWAIT, wait_cnt<=1. Branch and load-use are ignored this cycle.
- Single-cycle access (mem_memAccess=1, mem_ready=1 in RUN): no stall.
- Branch (ex_branchTaken=1): ifid_flush=1, idex_flush=1, pc_en=1. Any load-use hit is suppressed because the ID instruction is squashed.
- Load-use hit = ex_memRead & (ex_rt!=0) & (ex_rt==id_rs | (id_usesRt & ex_rt==id_rt)). On hit: pc_en=0, ifid_en=0, idex_flush=1; exmem_en=1, memwb_bubble=0. Lasts exactly one cycle, because the load then leaves EX.
- MWAIT, mem_ready=0: same frozen outputs as memory stall, mem_req=1, wait_cnt++. If wait_cnt==TIMEOUT: next FAULT, fault<=1.
- MWAIT, mem_ready=1: mem_req=1, memwb_bubble=0, pipeline released. Branch and load-use are evaluated as in RUN, with no memory-stall term. Next RUN, wait_cnt<=0.
- FAULT: all enables 0, flush/bubble 0, mem_req=0, fault=1. Exit only via reset. mem_ready is ignored.
- stall_cycles increments on every post-reset cycle with pc_en=0, including FAULT. It saturates at 2^CNT_W-1 and does not wrap.
- A reset assertion mid-MWAIT aborts the access immediately: mem_req drops in the same cycle (combinational on reset).

Test Plan:
- Load-use: ex_memRead=1, ex_rt=5, id_rs=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cycles 0->1. Repeat with ex_rt=0 -> no stall.
- Branch + load-use same cycle: ex_branchTaken=1 with load-use hit -> pc_en=1, ifid_flush=1, idex_flush=1; stall_cycles unchanged.
- Memory wait: mem_memAccess=1, mem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles plus release cycle; mem_req high 4 cycles; memwb_bubble high first 3; stall_cycles=3; state back to RUN.
- Timeout: TIMEOUT=4, mem_ready held 0 -> fault=1 after the stall cycle plus 4 MWAIT cycles; mem_req=0 and all enables 0 thereafter; mem_ready=1 later has no effect.
- Reset mid-wait: reset=0 asserted asynchronously (between edges) in MWAIT -> mem_req=0 and stall_cycles=0 immediately. After release, state RUN and normal operation resumes.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for a 5-stage MIPS pipeline.
//   - Detects load-use hazards (ID reads a register an EX-stage load writes)
//     and taken branches resolved in EX.
//   - Runs a multi-cycle data-memory wait: while MEM waits on mem_ready the
//     whole front of the pipeline is frozen and MEM/WB is fed bubbles.
//   - Counts cycles with the PC held (saturating) and raises a sticky fault
//     if the memory never answers within TIMEOUT wait cycles.
// Ports:
//   clk, reset (async, active-low)
//   id_rs, id_rt, id_usesRt          : source operands of the ID instruction
//   ex_memRead, ex_rt, ex_branchTaken: EX-stage load / branch information
//   mem_memAccess, mem_ready         : MEM-stage access and memory handshake
//   mem_req                          : data-memory access pending/held
//   pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble
//                                    : per-pipeline-register controls
//   stall_cycles                     : saturating count of pc_en=0 cycles
//   fault                            : sticky memory-timeout flag
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_usesRt,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branchTaken,
  input  logic             mem_memAccess,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             fault
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MWAIT, FAULT} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_q;
  logic              fault_q, fault_d;
  logic              load_use;

  // $0 is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = ex_memRead && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_usesRt && (ex_rt == id_rt)));

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    mem_req      = mem_memAccess;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    fault_d      = fault_q;

    unique case (state_q)
      RUN, MWAIT: begin
        if ((state_q == RUN && mem_memAccess && !mem_ready) ||
            (state_q == MWAIT && !mem_ready)) begin
          // Memory not done: freeze everything up to EX/MEM, drain bubbles.
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_en     = 1'b0;
          memwb_bubble = 1'b1;
          mem_req      = 1'b1;
          if (state_q == RUN) begin
            state_d    = MWAIT;
            wait_cnt_d = WC_W'(1);
          end else if (wait_cnt_q == WC_W'(TIMEOUT)) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end else begin
          if (state_q == MWAIT) begin
            // Release cycle: the access completes now, keep the request up.
            mem_req    = 1'b1;
            state_d    = RUN;
            wait_cnt_d = '0;
          end
          // A taken branch squashes the ID instruction, so it wins over load-use.
          if (ex_branchTaken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
      FAULT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        mem_req  = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Reset gates every control immediately, aborting any pending access.
    if (!reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_en      = 1'b0;
      idex_flush   = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b0;
      mem_req      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      if (!pc_en && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign fault        = fault_q;

endmodule
